tran_det_n: RTL

//  - N-channel edge/transition detector for the DAC digital path, the parametrised successor of the 6-input rising-edge detector.
//  - Selectable edge mode (rise/fall/both/off), per-channel transition flags and per-channel saturating transition counts over a programmable window.
//  - Sits after the element-selection logic; its counts monitor DAC unit-element switching activity.

---
 rtl/tran_det_pkg.sv | 25 ++
 rtl/tran_det_ch.sv | 61 ++++++
 rtl/tran_det_n.sv | 105 ++++++++++
 3 files changed

// File: rtl/tran_det_pkg.sv
// Shared definitions for the N-channel transition detector:
// edge-mode encodings and the saturating increment used by the per-channel
// accumulators.
package tran_det_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Add inc to val, holding at the all-ones value of a width-bit counter.
  // Widths above 32 are not supported by the callers.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    if (inc && (val < max_v)) begin
      sat_inc = val + 32'd1;
    end else begin
      sat_inc = val;
    end
  endfunction

endpackage

// File: rtl/tran_det_ch.sv
// One detector channel: previous-sample bit, edge decode, saturating
// transition accumulator and the window snapshot register.
module tran_det_ch
  import tran_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sv_bit,
  input  logic             acc_clr,
  input  logic             snap,
  output logic             st,
  output logic [CNT_W-1:0] cnt
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_inc;

  // Edge decode against the previous sample; forced low when disabled.
  always_comb begin
    st = 1'b0;
    if (en) begin
      case (mode)
        MODE_RISE: st = sv_bit & ~prev_q;
        MODE_FALL: st = ~sv_bit & prev_q;
        MODE_BOTH: st = sv_bit ^ prev_q;
        default:   st = 1'b0;
      endcase
    end
  end

  // Next state: prev always tracks sv; the snapshot captures acc plus the
  // current flag so the window-end cycle is counted.
  always_comb begin
    prev_d  = sv_bit;
    acc_inc = CNT_W'(sat_inc(32'(acc_q), st, unsigned'(CNT_W)));
    acc_d   = acc_clr ? '0 : acc_inc;
    cnt_d   = snap ? acc_inc : cnt_q;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tran_det_n.sv
// N-channel transition detector with selectable edge mode, per-channel
// saturating transition counts and a programmable snapshot window.
// Optional macro TRAN_DET_REG_OUT_EN registers st/st_any (1-cycle latency);
// accumulation always uses the unregistered flags, so window timing is the
// same in both builds.
module tran_det_n
  import tran_det_pkg::*;
#(
  parameter int N     = 6,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               clr,
  input  logic [WIN_W-1:0]   win_len,
  input  logic [N-1:0]       sv,
  output logic [N-1:0]       st,
  output logic               st_any,
  output logic [N*CNT_W-1:0] cnt_bus,
  output logic               win_done
);

  logic [WIN_W-1:0] wcnt_q, wcnt_d;
  logic             win_done_q, win_done_d;
  logic             win_end;
  logic             snap;
  logic             acc_clr;
  logic [N-1:0]     st_raw;

  // Window end uses >= so a win_len lowered below wcnt closes the window
  // on the next enabled cycle; clr overrides a coinciding window end.
  always_comb begin
    win_end    = en && (win_len != '0) && (wcnt_q >= (win_len - WIN_W'(1)));
    snap       = win_end && !clr;
    acc_clr    = clr || win_end;
    win_done_d = snap;
    wcnt_d     = wcnt_q;
    if (clr || (win_len == '0)) begin
      wcnt_d = '0;
    end else if (en) begin
      wcnt_d = win_end ? '0 : (wcnt_q + WIN_W'(1));
    end
  end

  // Window counter and snapshot-valid pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_q     <= '0;
      win_done_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      win_done_q <= win_done_d;
    end
  end

  assign win_done = win_done_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    tran_det_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .en      (en),
      .mode    (mode),
      .sv_bit  (sv[gi]),
      .acc_clr (acc_clr),
      .snap    (snap),
      .st      (st_raw[gi]),
      .cnt     (cnt_bus[gi*CNT_W +: CNT_W])
    );
  end

`ifdef TRAN_DET_REG_OUT_EN
  logic [N-1:0] st_q, st_d;
  logic         st_any_q, st_any_d;

  // Registered flag outputs.
  always_comb begin
    st_d     = st_raw;
    st_any_d = |st_raw;
  end

  // Output flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q     <= '0;
      st_any_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      st_any_q <= st_any_d;
    end
  end

  assign st     = st_q;
  assign st_any = st_any_q;
`else
  assign st     = st_raw;
  assign st_any = |st_raw;
`endif

endmodule
